// File: rtl/i2c_regmap_pkg.sv
// Register map constants and shared types for the redriver
// I2C register bank.
package i2c_regmap_pkg;

  localparam int NUM_CH = 4;

  localparam logic [7:0] ADDR_ID       = 8'h00;
  localparam logic [7:0] ADDR_CTRL     = 8'h01;
  localparam logic [7:0] ADDR_STATUS   = 8'h02;
  localparam logic [7:0] ADDR_IRQ_MASK = 8'h03;
  localparam logic [7:0] ADDR_EQ0      = 8'h04;
  localparam logic [7:0] ADDR_GAIN0    = 8'h08;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_SOFT = 1;
  localparam int CTRL_LOCK = 7;

  typedef enum logic [1:0] {
    RGN_CORE,
    RGN_EQ,
    RGN_GAIN,
    RGN_NONE
  } region_e;

  typedef struct packed {
    logic       en;
    logic [7:0] off;
    logic [7:0] dat;
  } wr_req_t;

  // Offsets are grouped in aligned blocks of four
  function automatic region_e region_of(
    input logic [7:0] off
  );
    region_e r;
    r = RGN_NONE;
    unique case (1'b1)
      (off[7:2] == ADDR_ID[7:2]):    r = RGN_CORE;
      (off[7:2] == ADDR_EQ0[7:2]):   r = RGN_EQ;
      (off[7:2] == ADDR_GAIN0[7:2]): r = RGN_GAIN;
      default:                       r = RGN_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/i2c_reg_bank_sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
// Each bit is synchronized independently.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             SYSTEM_CLK,
  input  logic             RESETn,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = din;
    sync_d = meta_q;
  end

  always_ff @(posedge SYSTEM_CLK or negedge RESETn) begin
    if (!RESETn) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign dout = sync_q;

endmodule

// File: rtl/i2c_reg_bank.sv
// Redriver register bank behind the I2C slave: EQ/gain config,
// control, IRQ mask and sticky loss-of-signal status.
module i2c_reg_bank
  import i2c_regmap_pkg::*;
#(
  parameter logic [7:0] DEV_ID       = 8'hA5,
  parameter logic [7:0] EQ_DEFAULT   = 8'h04,
  parameter logic [7:0] GAIN_DEFAULT = 8'h02
) (
  input  logic        SYSTEM_CLK,
  input  logic        RESETn,
  input  logic [7:0]  rx_offset,
  input  logic [7:0]  rx_data,
  input  logic        owrite_en,
  input  logic        oread_en,
  output logic [7:0]  tx_data,
  input  logic [3:0]  status_in,
  output logic        global_en,
  output logic [31:0] eq_cfg,
  output logic [31:0] gain_cfg,
  output logic        cfg_update,
  output logic        status_irq
);

  logic                   owr_q, owr_d;
  logic [7:0]             ctrl_q, ctrl_d;
  logic [3:0]             stat_q, stat_d;
  logic [3:0]             mask_q, mask_d;
  logic [NUM_CH-1:0][7:0] eq_q, eq_d;
  logic [NUM_CH-1:0][7:0] gain_q, gain_d;
  logic                   soft_q, soft_d;
  logic                   soft_done_q, soft_done_d;
  logic                   upd_q, upd_d;
  logic                   cfg_update_q, cfg_update_d;
  logic                   status_irq_q, status_irq_d;
  logic [7:0]             tx_data_q, tx_data_d;

  wr_req_t     wr;
  region_e     rgn;
  logic        locked;
  logic        wr_ctrl, wr_stat, wr_mask;
  logic        wr_eq, wr_gain;
  logic [3:0]  los_sync;
  logic        rd_unused;

  // Read load is level-held by the slave; tx_data is refreshed
  // every cycle so the strobe itself carries no state.
  assign rd_unused = oread_en;

  sync_2ff #(
    .WIDTH (NUM_CH)
  ) u_los_sync (
    .SYSTEM_CLK (SYSTEM_CLK),
    .RESETn     (RESETn),
    .din        (status_in),
    .dout       (los_sync)
  );

  always_comb begin
    owr_d   = owrite_en;
    wr.en   = owrite_en & ~owr_q;
    wr.off  = rx_offset;
    wr.dat  = rx_data;
    rgn     = region_of(wr.off);
    locked  = ctrl_q[CTRL_LOCK];
    wr_ctrl = wr.en && (wr.off == ADDR_CTRL);
    wr_stat = wr.en && (wr.off == ADDR_STATUS);
    wr_mask = wr.en && (wr.off == ADDR_IRQ_MASK);
    wr_eq   = wr.en && (rgn == RGN_EQ) && !locked;
    wr_gain = wr.en && (rgn == RGN_GAIN) && !locked;
  end

  always_comb begin
    ctrl_d = ctrl_q;
    if (wr_ctrl) begin
      ctrl_d            = wr.dat;
      ctrl_d[CTRL_SOFT] = 1'b0;
    end
    mask_d = wr_mask ? wr.dat[3:0] : mask_q;
    // A new synchronized flag beats a coincident clear
    stat_d = (stat_q & ~(wr_stat ? wr.dat[3:0] : 4'h0))
           | los_sync;
    eq_d   = eq_q;
    gain_d = gain_q;
    if (wr_eq)   eq_d[wr.off[1:0]]   = wr.dat;
    if (wr_gain) gain_d[wr.off[1:0]] = wr.dat;
    if (soft_q) begin
      eq_d   = {NUM_CH{EQ_DEFAULT}};
      gain_d = {NUM_CH{GAIN_DEFAULT}};
    end
  end

  // Soft reset defers its single update pulse until after reload
  always_comb begin
    soft_d       = wr_ctrl & wr.dat[CTRL_SOFT];
    soft_done_d  = soft_q;
    upd_d        = wr_eq | wr_gain
                 | (wr_ctrl & ~wr.dat[CTRL_SOFT]);
    cfg_update_d = upd_q | soft_done_q;
    status_irq_d = |(stat_q & mask_q);
  end

  always_comb begin
    tx_data_d = 8'h00;
    unique case (1'b1)
      (rgn == RGN_EQ):
        tx_data_d = eq_q[rx_offset[1:0]];
      (rgn == RGN_GAIN):
        tx_data_d = gain_q[rx_offset[1:0]];
      (rx_offset == ADDR_ID):
        tx_data_d = DEV_ID;
      (rx_offset == ADDR_CTRL):
        tx_data_d = ctrl_q;
      (rx_offset == ADDR_STATUS):
        tx_data_d = {4'h0, stat_q};
      (rx_offset == ADDR_IRQ_MASK):
        tx_data_d = {4'h0, mask_q};
      default:
        tx_data_d = 8'h00;
    endcase
  end

  always_ff @(posedge SYSTEM_CLK or negedge RESETn) begin
    if (!RESETn) begin
      owr_q        <= 1'b0;
      ctrl_q       <= 8'h00;
      stat_q       <= 4'h0;
      mask_q       <= 4'h0;
      eq_q         <= {NUM_CH{EQ_DEFAULT}};
      gain_q       <= {NUM_CH{GAIN_DEFAULT}};
      soft_q       <= 1'b0;
      soft_done_q  <= 1'b0;
      upd_q        <= 1'b0;
      cfg_update_q <= 1'b0;
      status_irq_q <= 1'b0;
      tx_data_q    <= 8'h00;
    end else begin
      owr_q        <= owr_d;
      ctrl_q       <= ctrl_d;
      stat_q       <= stat_d;
      mask_q       <= mask_d;
      eq_q         <= eq_d;
      gain_q       <= gain_d;
      soft_q       <= soft_d;
      soft_done_q  <= soft_done_d;
      upd_q        <= upd_d;
      cfg_update_q <= cfg_update_d;
      status_irq_q <= status_irq_d;
      tx_data_q    <= tx_data_d;
    end
  end

  assign tx_data    = tx_data_q;
  assign global_en  = ctrl_q[CTRL_EN];
  assign eq_cfg     = eq_q;
  assign gain_cfg   = gain_q;
  assign cfg_update = cfg_update_q;
  assign status_irq = status_irq_q;

endmodule

// File: tb/tb_i2c_reg_bank.sv
// Directed table-driven bench for i2c_reg_bank.
// Covers reset, map, lock, soft reset, status and reset abort.
module tb_i2c_reg_bank;

  logic        SYSTEM_CLK;
  logic        RESETn;
  logic [7:0]  rx_offset;
  logic [7:0]  rx_data;
  logic        owrite_en;
  logic        oread_en;
  logic [7:0]  tx_data;
  logic [3:0]  status_in;
  logic        global_en;
  logic [31:0] eq_cfg;
  logic [31:0] gain_cfg;
  logic        cfg_update;
  logic        status_irq;

  int checks = 0;
  int errors = 0;
  int p, f;
  logic [7:0] t;

  localparam logic [31:0] E0 = 32'h04040404;
  localparam logic [31:0] E1 = 32'h04043C04;
  localparam logic [31:0] E2 = 32'h04113C04;
  localparam logic [31:0] G0 = 32'h02020202;
  localparam logic [31:0] G1 = 32'h020202FF;
  localparam logic [31:0] G3 = 32'h9A020202;

  typedef struct {
    bit          wr;
    logic [7:0]  off;
    logic [7:0]  dat;
    int          hold;
    logic [7:0]  exp_tx;
    int          exp_pulses;
    int          exp_first;
    logic [31:0] exp_eq;
    logic [31:0] exp_gain;
    logic        exp_gen;
  } vec_t;

  vec_t tbl[$];

  i2c_reg_bank dut (
    .SYSTEM_CLK (SYSTEM_CLK),
    .RESETn     (RESETn),
    .rx_offset  (rx_offset),
    .rx_data    (rx_data),
    .owrite_en  (owrite_en),
    .oread_en   (oread_en),
    .tx_data    (tx_data),
    .status_in  (status_in),
    .global_en  (global_en),
    .eq_cfg     (eq_cfg),
    .gain_cfg   (gain_cfg),
    .cfg_update (cfg_update),
    .status_irq (status_irq)
  );

  initial SYSTEM_CLK = 1'b0;
  always #5 SYSTEM_CLK = ~SYSTEM_CLK;

  function automatic vec_t rv(
    input logic [7:0] off, input logic [7:0] tx,
    input logic [31:0] eq, input logic [31:0] gn,
    input logic gen
  );
    vec_t r;
    r.wr = 0; r.off = off; r.dat = 8'h00; r.hold = 0;
    r.exp_tx = tx; r.exp_pulses = 0; r.exp_first = 0;
    r.exp_eq = eq; r.exp_gain = gn; r.exp_gen = gen;
    return r;
  endfunction

  function automatic vec_t wv(
    input logic [7:0] off, input logic [7:0] dat,
    input int hold, input int pulses, input int first,
    input logic [31:0] eq, input logic [31:0] gn,
    input logic gen
  );
    vec_t r;
    r.wr = 1; r.off = off; r.dat = dat; r.hold = hold;
    r.exp_tx = 8'h00; r.exp_pulses = pulses;
    r.exp_first = first;
    r.exp_eq = eq; r.exp_gain = gn; r.exp_gen = gen;
    return r;
  endfunction

  task automatic step();
    @(posedge SYSTEM_CLK);
    #1;
  endtask

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic rd(input logic [7:0] off,
                    output logic [7:0] d);
    rx_offset = off;
    oread_en  = 1'b1;
    step();
    d = tx_data;
    oread_en  = 1'b0;
  endtask

  task automatic wr(
    input logic [7:0] off, input logic [7:0] dat,
    input int hold, output int pulses, output int first
  );
    pulses    = 0;
    first     = 0;
    rx_offset = off;
    rx_data   = dat;
    owrite_en = 1'b1;
    for (int i = 1; i <= hold + 4; i++) begin
      step();
      if (cfg_update) begin
        pulses++;
        if (first == 0) first = i;
      end
      if (i == hold) owrite_en = 1'b0;
    end
  endtask

  initial begin
    RESETn    = 1'b0;
    rx_offset = 8'h00;
    rx_data   = 8'h00;
    owrite_en = 1'b0;
    oread_en  = 1'b0;
    status_in = 4'h0;

    tbl.push_back(rv(8'h00, 8'hA5, E0, G0, 0));
    tbl.push_back(rv(8'h04, 8'h04, E0, G0, 0));
    tbl.push_back(rv(8'h08, 8'h02, E0, G0, 0));
    tbl.push_back(rv(8'h01, 8'h00, E0, G0, 0));
    tbl.push_back(rv(8'h02, 8'h00, E0, G0, 0));
    tbl.push_back(rv(8'h03, 8'h00, E0, G0, 0));
    tbl.push_back(wv(8'h05, 8'h3C, 20, 1, 2, E1, G0, 0));
    tbl.push_back(rv(8'h05, 8'h3C, E1, G0, 0));
    tbl.push_back(wv(8'h01, 8'h80, 3, 1, 2, E1, G0, 0));
    tbl.push_back(rv(8'h01, 8'h80, E1, G0, 0));
    tbl.push_back(wv(8'h08, 8'hFF, 2, 0, 0, E1, G0, 0));
    tbl.push_back(rv(8'h08, 8'h02, E1, G0, 0));
    tbl.push_back(wv(8'h04, 8'h77, 1, 0, 0, E1, G0, 0));
    tbl.push_back(wv(8'h01, 8'h00, 1, 1, 2, E1, G0, 0));
    tbl.push_back(wv(8'h08, 8'hFF, 1, 1, 2, E1, G1, 0));
    tbl.push_back(rv(8'h08, 8'hFF, E1, G1, 0));
    tbl.push_back(wv(8'h06, 8'h11, 1, 1, 2, E2, G1, 0));
    tbl.push_back(rv(8'h06, 8'h11, E2, G1, 0));
    tbl.push_back(wv(8'h01, 8'h83, 1, 1, 3, E0, G0, 1));
    tbl.push_back(rv(8'h01, 8'h81, E0, G0, 1));
    tbl.push_back(rv(8'h06, 8'h04, E0, G0, 1));
    tbl.push_back(rv(8'h08, 8'h02, E0, G0, 1));
    tbl.push_back(wv(8'h20, 8'h55, 1, 0, 0, E0, G0, 1));
    tbl.push_back(rv(8'h20, 8'h00, E0, G0, 1));
    tbl.push_back(wv(8'h03, 8'h04, 1, 0, 0, E0, G0, 1));
    tbl.push_back(rv(8'h03, 8'h04, E0, G0, 1));
    tbl.push_back(wv(8'h03, 8'hF4, 1, 0, 0, E0, G0, 1));
    tbl.push_back(rv(8'h03, 8'h04, E0, G0, 1));
    tbl.push_back(wv(8'h01, 8'h01, 1, 1, 2, E0, G0, 1));
    tbl.push_back(rv(8'h01, 8'h01, E0, G0, 1));
    tbl.push_back(wv(8'h0B, 8'h9A, 1, 1, 2, E0, G3, 1));
    tbl.push_back(rv(8'h0B, 8'h9A, E0, G3, 1));
    tbl.push_back(wv(8'h0C, 8'h77, 1, 0, 0, E0, G3, 1));
    tbl.push_back(rv(8'h0C, 8'h00, E0, G3, 1));
    tbl.push_back(rv(8'hFF, 8'h00, E0, G3, 1));

    step();
    step();
    chk("rst_tx", tx_data, 8'h00);
    chk("rst_upd", cfg_update, 1'b0);
    chk("rst_irq", status_irq, 1'b0);
    chk("rst_gen", global_en, 1'b0);
    chk("rst_eq", eq_cfg, E0);
    chk("rst_gain", gain_cfg, G0);
    RESETn = 1'b1;
    step();

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].wr) begin
        wr(tbl[i].off, tbl[i].dat, tbl[i].hold, p, f);
        chk($sformatf("v%0d_pulses", i), p,
            tbl[i].exp_pulses);
        if (tbl[i].exp_pulses > 0)
          chk($sformatf("v%0d_first", i), f,
              tbl[i].exp_first);
      end else begin
        rd(tbl[i].off, t);
        chk($sformatf("v%0d_tx", i), t, tbl[i].exp_tx);
      end
      chk($sformatf("v%0d_eq", i), eq_cfg, tbl[i].exp_eq);
      chk($sformatf("v%0d_gain", i), gain_cfg,
          tbl[i].exp_gain);
      chk($sformatf("v%0d_gen", i), global_en,
          tbl[i].exp_gen);
    end

    status_in = 4'b0100;
    step();
    status_in = 4'h0;
    repeat (5) step();
    chk("st_irq_set", status_irq, 1'b1);
    rd(8'h02, t);
    chk("st_read_set", t, 8'h04);
    wr(8'h02, 8'h04, 1, p, f);
    chk("st_w1c_pulses", p, 0);
    rd(8'h02, t);
    chk("st_read_clr", t, 8'h00);
    chk("st_irq_clr", status_irq, 1'b0);

    status_in = 4'b0100;
    step();
    status_in = 4'h0;
    step();
    wr(8'h02, 8'h04, 1, p, f);
    rd(8'h02, t);
    chk("st_set_wins", t, 8'h04);
    chk("st_set_wins_irq", status_irq, 1'b1);
    wr(8'h03, 8'h00, 1, p, f);
    chk("st_masked_irq", status_irq, 1'b0);

    rx_offset = 8'h04;
    rx_data   = 8'h99;
    owrite_en = 1'b1;
    step();
    chk("ar_pre_eq", eq_cfg, 32'h04040499);
    RESETn    = 1'b0;
    owrite_en = 1'b0;
    #1;
    chk("ar_eq", eq_cfg, E0);
    chk("ar_gain", gain_cfg, G0);
    chk("ar_gen", global_en, 1'b0);
    chk("ar_tx", tx_data, 8'h00);
    step();
    step();
    RESETn = 1'b1;
    p = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (cfg_update) p++;
    end
    chk("ar_no_upd", p, 0);
    rd(8'h02, t);
    chk("ar_status", t, 8'h00);
    rd(8'h01, t);
    chk("ar_ctrl", t, 8'h00);
    rd(8'h0B, t);
    chk("ar_gain3", t, 8'h02);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
